pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage OpenMIPS core. It merges stall requests from the decode and execute stages into a per-stage stall vector. It also sequences one-cycle pipeline flushes carrying a redirect PC, and keeps a stall-cycle performance counter. It sits beside the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives all of their hold/flush controls.

## Interface
- `PC_W`, default 32, width of the redirect address.
- `PERF_W`, default 32, width of the stall-cycle counter.
- `WDOG_CYCLES`, default 255, consecutive-stall limit for the watchdog (legal range 1..2^16-1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_id`  in  1  ID needs an operand not yet available (load-use); hold PC, IF, ID.
- `stallreq_ex`  in  1  EX multi-cycle operation busy; hold PC, IF, ID, EX.
- `flush_req`  in  1  MEM-stage redirect (exception/eret); single-cycle pulse or level.
- `flush_pc_i`  in  PC_W  redirect target, valid with `flush_req`.
- `stall_o`  out  6  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (always 0).
- `flush_o`  out  1  invalidate all pipeline registers and load `new_pc_o`.
- `new_pc_o`  out  PC_W  redirect address, valid while `flush_o`=1.
- `stall_cnt_o`  out  PERF_W  total cycles with `stall_o`≠0 since reset.
- `wdog_err_o`  out  1  sticky: a stall exceeded `WDOG_CYCLES` consecutive cycles.

## Operation
- FSM with states RUN, STALL and FLUSH. Reset state is RUN.
- `stall_o` is combinational from the inputs and the state. Priority is rst > FLUSH state > `flush_req` > `stallreq_ex` > `stallreq_id`.
  - rst=1: 6'b000000.
  - State FLUSH: 6'b000000. Stall requests are ignored because the stages are being invalidated.
  - `flush_req`=1: 6'b000000.
  - Else `stallreq_ex`=1: 6'b001111.
  - Else `stallreq_id`=1: 6'b000111.
  - Else 6'b000000.
- Transitions, evaluated at each posedge:
  - Any state with `flush_req`=1 goes to FLUSH. `new_pc_o` <= `flush_pc_i`.
  - RUN or STALL with `stall_o`≠0 goes to STALL.
  - RUN or STALL otherwise goes to RUN.
  - FLUSH with `flush_req`=0 goes to RUN.
- `flush_o` is registered and equals 1 exactly while in state FLUSH.
- A back-to-back `flush_req` keeps the FSM in FLUSH for another cycle and relatches `new_pc_o`, so the newest target wins.
- `new_pc_o` holds its last value outside FLUSH. Consumers use it only with `flush_o`.
- `stall_cnt_o` increments by 1 on each posedge where `stall_o`≠0. It saturates at 2^PERF_W−1 and does not wrap.
- Reset values: state RUN, `flush_o`=0, `new_pc_o`=0, `stall_cnt_o`=0, `wdog_err_o`=0, consecutive-stall counter 0. `stall_o`=0 combinationally while rst=1.
- A reset during STALL or FLUSH returns to RUN at the next edge. Requests present in the reset cycle are discarded.

## Timing
- Stall has 0-cycle latency: `stall_o` follows the requests in the same cycle.
- Flush has 1-cycle latency: `flush_req` sampled at edge N gives `flush_o`=1 and a valid `new_pc_o` during cycle N+1. `flush_o` is one cycle wide per accepted request.
- In the first cycle after FLUSH, stall requests act immediately.
- The counter update uses the same-cycle `stall_o`, so a 3-cycle stall adds exactly 3.

## Configuration
- `PIPE_CTRL_WDOG_EN` defined:
  - A 16-bit consecutive-stall counter increments while `stall_o`≠0 and clears on any cycle with `stall_o`=0 or in FLUSH.
  - When it reaches `WDOG_CYCLES`, `wdog_err_o` sets to 1 on that edge and stays 1 until rst.
  - The stall itself is not released by the watchdog.
- `PIPE_CTRL_WDOG_EN` undefined: the counter is not built and `wdog_err_o` is tied to 0.

## Test plan
- Reset: rst=1 for 2 cycles with all requests high -> `stall_o`=0, `flush_o`=0, `new_pc_o`=0, `stall_cnt_o`=0. After release with requests low, state is RUN.
- Stall priority:
  - `stallreq_id`=1 for 2 cycles -> `stall_o`=6'b000111 both cycles.
  - Then `stallreq_id`=`stallreq_ex`=1 -> `stall_o`=6'b001111.
  - `stall_cnt_o` ends at 3.
- Flush over stall: `stallreq_ex`=1 and `flush_req`=1 with `flush_pc_i`=32'h0000_0140 in one cycle -> `stall_o`=0 that cycle. Next cycle: `flush_o`=1, `new_pc_o`=32'h0000_0140, `stall_o`=0 despite `stallreq_ex` still 1. The cycle after: `flush_o`=0, `stall_o`=6'b001111.
- Back-to-back flush: `flush_req` on 2 consecutive cycles with targets 32'h100 then 32'h200 -> `flush_o`=1 for 2 cycles, `new_pc_o`=32'h100 then 32'h200.
- Saturation and watchdog:
  - PERF_W=4 with 20 stall cycles -> `stall_cnt_o`=15.
  - With `PIPE_CTRL_WDOG_EN` and `WDOG_CYCLES`=8, a continuous stall -> `wdog_err_o` rises after the 8th stall cycle and stays 1 after the stall ends. Without the macro it stays 0.
- Reset mid-operation: assert rst in the FLUSH cycle -> next cycle `flush_o`=0, `new_pc_o`=0, `stall_cnt_o`=0, `wdog_err_o`=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the OpenMIPS stage registers and pipe_ctrl.
// The master side is the pipeline. The slave side is the controller.
interface pipe_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int PERF_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic [PC_W-1:0]   new_pc_o;
  logic [PERF_W-1:0] stall_cnt_o;
  logic              wdog_err_o;

  modport master (
    output stallreq_id, stallreq_ex, flush_req, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, stall_cnt_o, wdog_err_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, flush_req, flush_pc_i,
    output stall_o, flush_o, new_pc_o, stall_cnt_o, wdog_err_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall merge, flush sequencing and stall performance counter for the 5-stage pipe.
// Optional consecutive-stall watchdog is built when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl #(
  parameter int PC_W        = 32,
  parameter int PERF_W      = 32,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_e            state_q;
  logic              flush_q;
  logic [PC_W-1:0]   new_pc_q;
  logic [PERF_W-1:0] cnt_q;
  logic [5:0]        stall_vec;
  logic              stalled;

  // Stages being invalidated must not hold, so a flush masks every stall request.
  always_comb begin
    stall_vec = 6'b000000;
    if (rst || state_q == FLUSH || bus.flush_req)
      stall_vec = 6'b000000;
    else if (bus.stallreq_ex)
      stall_vec = STALL_EX;
    else if (bus.stallreq_id)
      stall_vec = STALL_ID;
  end

  assign stalled = |stall_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (bus.flush_req) begin
        state_q  <= FLUSH;
        flush_q  <= 1'b1;
        new_pc_q <= bus.flush_pc_i;
      end else begin
        state_q <= stalled ? STALL : RUN;
        flush_q <= 1'b0;
      end
      if (stalled && cnt_q != {PERF_W{1'b1}})
        cnt_q <= cnt_q + PERF_W'(1);
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

  logic [15:0] wdog_cnt_q;
  logic        wdog_err_q;

  // Run length stops at the limit; the sticky flag already records the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (stalled && state_q != FLUSH) begin
      if (wdog_cnt_q != WDOG_LIM)
        wdog_cnt_q <= wdog_cnt_q + 16'd1;
      if (wdog_cnt_q + 16'd1 == WDOG_LIM)
        wdog_err_q <= 1'b1;
    end else begin
      wdog_cnt_q <= '0;
    end
  end

  assign bus.wdog_err_o = wdog_err_q;
`else
  logic [31:0] unused_wdog;
  assign unused_wdog    = WDOG_CYCLES;
  assign bus.wdog_err_o = 1'b0;
`endif

  assign bus.stall_o     = stall_vec;
  assign bus.flush_o     = flush_q;
  assign bus.new_pc_o    = new_pc_q;
  assign bus.stall_cnt_o = cnt_q;
endmodule
